// File: rtl/hawk_axi_rd_arb.sv
// rtl/hawk_axi_rd_arb.sv - round-robin arbiter sharing one AXI4 read master port
// One transaction outstanding; R channel routed to the granted requester; beat-count and stall checks.
module hawk_axi_rd_arb #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DATA_W      = 512,
   parameter int unsigned RESP_W      = 2,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        s_arvalid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] s_araddr_i,
   input  logic [NUM_REQ*8-1:0]      s_arlen_i,
   output logic [NUM_REQ-1:0]        s_arready_o,
   output logic [NUM_REQ-1:0]        s_rvalid_o,
   input  logic [NUM_REQ-1:0]        s_rready_i,
   output logic [DATA_W-1:0]         s_rdata_o,
   output logic [RESP_W-1:0]         s_rresp_o,
   output logic                      s_rlast_o,
   output logic                      m_arvalid_o,
   output logic [ADDR_W-1:0]         m_araddr_o,
   output logic [7:0]                m_arlen_o,
   input  logic                      m_arready_i,
   input  logic                      m_rvalid_i,
   input  logic [DATA_W-1:0]         m_rdata_i,
   input  logic [RESP_W-1:0]         m_rresp_i,
   input  logic                      m_rlast_i,
   output logic                      m_rready_o,
   output logic                      busy_o,
   output logic [2:0]                gnt_id_o,
   output logic                      err_o,
   output logic [1:0]                err_code_o,
   output logic [1:0]                arb_state_o
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] CODE_TIMEOUT = 2'd1;
   localparam logic [1:0] CODE_EARLY   = 2'd2;
   localparam logic [1:0] CODE_MISSING = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          gnt_q, gnt_d;
   logic [2:0]          rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          beat_q, beat_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [1:0]          code_q, code_d;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] req_shift;
   logic [NUM_REQ-1:0]   req_rot;
   logic                 req_any;
   logic [3:0]           pick_off;
   logic [3:0]           pick_sum;
   logic [2:0]           pick;
   logic [3:0]           ptr_sum;
   logic [ADDR_W-1:0]    sel_addr;
   logic [7:0]           sel_len;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic                 gnt_rready;
   logic                 r_hs;

   // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the round-robin winner.
   assign req_dbl   = {s_arvalid_i, s_arvalid_i};
   assign req_shift = req_dbl >> rr_ptr_q;
   assign req_rot   = req_shift[NUM_REQ-1:0];
   assign req_any   = |s_arvalid_i;

   always_comb begin
      pick_off = 4'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_off = 4'(k);
         end
      end
      pick_sum = pick_off + {1'b0, rr_ptr_q};
      if (pick_sum >= 4'(NUM_REQ)) begin
         pick_sum = pick_sum - 4'(NUM_REQ);
      end
      pick = pick_sum[2:0];
      ptr_sum = {1'b0, pick} + 4'd1;
      if (ptr_sum >= 4'(NUM_REQ)) begin
         ptr_sum = 4'd0;
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == 3'(i)) begin
            sel_addr = s_araddr_i[i*ADDR_W +: ADDR_W];
            sel_len  = s_arlen_i[i*8 +: 8];
         end
      end
   end

   assign gnt_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
   assign gnt_rready = |(s_rready_i & gnt_oh);
   assign r_hs       = m_rvalid_i && gnt_rready;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      addr_d      = addr_q;
      len_d       = len_q;
      beat_d      = beat_q;
      tmo_d       = tmo_q;
      code_d      = code_q;
      m_arvalid_o = 1'b0;
      s_arready_o = '0;
      s_rvalid_o  = '0;
      m_rready_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               gnt_d    = pick;
               rr_ptr_d = ptr_sum[2:0];
               addr_d   = sel_addr;
               len_d    = sel_len;
               beat_d   = '0;
               tmo_d    = '0;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            m_arvalid_o = 1'b1;
            if (m_arready_i) begin
               s_arready_o = gnt_oh;
               state_d     = DATA;
            end
         end
         DATA: begin
            s_rvalid_o = m_rvalid_i ? gnt_oh : '0;
            m_rready_o = gnt_rready;
            if (r_hs) begin
               beat_d = beat_q + 8'd1;
               tmo_d  = '0;
               if (beat_q == len_q) begin
                  if (m_rlast_i) begin
                     state_d = IDLE;
                  end else begin
                     state_d = ERR;
                     code_d  = CODE_MISSING;
                  end
               end else if (m_rlast_i) begin
                  state_d = ERR;
                  code_d  = CODE_EARLY;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
               state_d = ERR;
               code_d  = CODE_TIMEOUT;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ERR: begin
            // Terminal: keep draining stray beats so the interconnect never wedges.
            m_rready_o = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         tmo_q    <= '0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         tmo_q    <= tmo_d;
         code_q   <= code_d;
      end
   end

   assign m_araddr_o  = addr_q;
   assign m_arlen_o   = len_q;
   assign s_rdata_o   = m_rdata_i;
   assign s_rresp_o   = m_rresp_i;
   assign s_rlast_o   = m_rlast_i;
   assign busy_o      = (state_q != IDLE);
   assign gnt_id_o    = gnt_q;
   assign err_o       = (state_q == ERR);
   assign err_code_o  = code_q;
   assign arb_state_o = state_q;

endmodule
